// File: rtl/vga_capture.sv
// Receive side of the 8-bit VGA stream: recovers pixel/line position from the sync edges,
// writes a fixed window into a frame-buffer port and measures line length and frame height.
module vga_capture #(
   parameter int CAP_X0 = 217,
   parameter int CAP_Y0 = 27,
   parameter int CAP_W  = 220,
   parameter int CAP_H  = 180,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              arm,
   input  logic              vga_hs,
   input  logic              vga_vs,
   input  logic [7:0]        vga_rgb,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_err,
   output logic [11:0]       h_total_meas,
   output logic [11:0]       v_total_meas
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WAIT_VS = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   localparam logic [11:0]       X_LO     = 12'(CAP_X0);
   localparam logic [11:0]       X_HI     = 12'(CAP_X0 + CAP_W - 1);
   localparam logic [11:0]       Y_LO     = 12'(CAP_Y0);
   localparam logic [11:0]       Y_HI     = 12'(CAP_Y0 + CAP_H - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CAP_W * CAP_H - 1);

   logic              hs_p0, hs_p1, vs_p0, vs_p1;
   logic [7:0]        rgb_p0;
   logic              hs_fall, vs_fall, in_win;
   logic [11:0]       h_cnt, v_cnt;
   logic [1:0]        state;
   logic [ADDR_W-1:0] idx;

   function automatic logic [11:0] sat_inc(input logic [11:0] v);
      return (v == 12'hFFF) ? v : v + 12'd1;
   endfunction

   assign hs_fall = hs_p1 & ~hs_p0;
   assign vs_fall = vs_p1 & ~vs_p0;
   assign in_win  = (h_cnt >= X_LO) && (h_cnt <= X_HI) && (v_cnt >= Y_LO) && (v_cnt <= Y_HI);

   // p0: input registers and position/measurement counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hs_p0        <= 1'b1;
         hs_p1        <= 1'b1;
         vs_p0        <= 1'b1;
         vs_p1        <= 1'b1;
         rgb_p0       <= '0;
         h_cnt        <= '0;
         v_cnt        <= '0;
         h_total_meas <= '0;
         v_total_meas <= '0;
      end else begin
         hs_p0  <= vga_hs;
         hs_p1  <= hs_p0;
         vs_p0  <= vga_vs;
         vs_p1  <= vs_p0;
         rgb_p0 <= vga_rgb;
         if (hs_fall) begin
            h_cnt        <= '0;
            h_total_meas <= sat_inc(h_cnt);
         end else begin
            h_cnt <= sat_inc(h_cnt);
         end
         // a vs edge coinciding with an hs edge restarts the line count without counting that hs
         if (vs_fall) begin
            v_cnt        <= '0;
            v_total_meas <= v_cnt;
         end else if (hs_fall) begin
            v_cnt <= sat_inc(v_cnt);
         end
      end
   end

   // p1: capture FSM and frame-buffer write port
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= (state == WAIT_VS) || (state == CAPTURE);
         case (state)
            IDLE: begin
               if (arm) state <= WAIT_VS;
            end
            WAIT_VS: begin
               if (!arm) begin
                  state <= IDLE;
               end else if (vs_fall) begin
                  state <= CAPTURE;
                  idx   <= '0;
               end
            end
            CAPTURE: begin
               if (vs_fall) begin
                  frame_err <= 1'b1;
                  idx       <= '0;
               end else if (in_win) begin
                  wr_en   <= 1'b1;
                  wr_data <= rgb_p0;
                  wr_addr <= idx;
                  idx     <= idx + ADDR_W'(1);
                  if (idx == LAST_IDX) state <= DONE;
               end
            end
            default: begin
               frame_done <= 1'b1;
               state      <= arm ? WAIT_VS : IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture: a sync generator drives a ramp image, expected writes are
// queued per frame and a monitor pops and compares them whenever wr_en is seen.
module tb_vga_capture;

   localparam int X0   = 217;
   localparam int Y0   = 2;
   localparam int W    = 220;
   localparam int H    = 3;
   localparam int AW   = 16;
   localparam int LAST = W * H - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          arm = 1'b0;
   logic          vga_hs = 1'b1;
   logic          vga_vs = 1'b1;
   logic [7:0]    vga_rgb = 8'd0;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          busy;
   logic          frame_done;
   logic          frame_err;
   logic [11:0]   h_total_meas;
   logic [11:0]   v_total_meas;

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   wr_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  n_done = 0;
   int  n_err = 0;

   int hl = 1056, hs_lo = 128, nl = 628, vs_off = 600;
   int inj_ln = -1, inj_px = 100;
   int px = 0, ln = 0;
   logic          prev_en = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   event ln_ev;

   vga_capture #(
      .CAP_X0(X0),
      .CAP_Y0(Y0),
      .CAP_W (W),
      .CAP_H (H),
      .ADDR_W(AW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .arm         (arm),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vga_rgb     (vga_rgb),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_err   (frame_err),
      .h_total_meas(h_total_meas),
      .v_total_meas(v_total_meas)
   );

   always #5 clk = ~clk;

   // Sync generator: pixel rgb = (px-1) so the captured value equals the DUT's h_cnt.
   initial begin
      forever begin
         @(negedge clk);
         if (px + 1 >= hl) begin
            px = 0;
            ln = (ln + 1 >= nl) ? 0 : ln + 1;
         end else begin
            px++;
         end
         vga_hs  = (px >= hs_lo);
         vga_vs  = !((ln == 0 && px >= vs_off) || (ln == 1 && px < vs_off) ||
                     (ln == inj_ln && px >= inj_px && px < inj_px + 10));
         vga_rgb = 8'(px - 1);
         if (px == 0) ->ln_ev;
      end
   end

   // Monitor: pops one expectation per observed write, counts pulses.
   initial begin
      forever begin
         wr_t e;
         @(negedge clk);
         if (wr_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL write_unexpected: got addr %0d data %0d, required no write", wr_addr, wr_data);
            end else begin
               e = exp_q.pop_front();
               if (wr_addr !== e.addr || wr_data !== e.data) begin
                  n_bad++;
                  $display("FAIL write: got addr %0d data %0d, required addr %0d data %0d",
                           wr_addr, wr_data, e.addr, e.data);
               end
            end
         end
         if (frame_done) begin
            n_done++;
            n_cmp++;
            if (!(prev_en && prev_addr == AW'(LAST))) begin
               n_bad++;
               $display("FAIL done_align: got prev wr_en %0b addr %0d, required 1 addr %0d",
                        prev_en, prev_addr, LAST);
            end
         end
         if (frame_err) n_err++;
         prev_en   = wr_en;
         prev_addr = wr_addr;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, required bench completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic push_frame(input int n);
      for (int i = 0; i < n; i++) begin
         wr_t e;
         e.addr = AW'(i);
         e.data = 8'(X0 + (i % W));
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_line(input int n);
      do @(ln_ev); while (ln != n);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_en"}, 32'(wr_en), 0);
      check({tag, "_wr_addr"}, 32'(wr_addr), 0);
      check({tag, "_wr_data"}, 32'(wr_data), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_frame_done"}, 32'(frame_done), 0);
      check({tag, "_frame_err"}, 32'(frame_err), 0);
      check({tag, "_h_total"}, 32'(h_total_meas), 0);
      check({tag, "_v_total"}, 32'(v_total_meas), 0);
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0;
      arm   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      // Line length at display-generator timing, capture disarmed.
      repeat (3) @(ln_ev);
      check("h_total_1056", 32'(h_total_meas), 1056);

      // Frame height 628 using very short lines to keep the run short.
      hl = 8; hs_lo = 2; vs_off = 4;
      wait_line(0);
      wait_line(0);
      repeat (2) @(ln_ev);
      check("v_total_628", 32'(v_total_meas), 628);
      check("h_total_8", 32'(h_total_meas), 8);
      check("idle_busy", 32'(busy), 0);

      // Capture timing: 600-clk lines, 8 lines/frame, vs mid-line at pixel 500.
      hl = 600; hs_lo = 64; nl = 8; vs_off = 500;
      wait_line(0);
      wait_line(5);
      arm = 1'b1;
      wait_line(0);                      // F1
      push_frame(W * H);
      wait_line(0);                      // F2
      check("done_after_f1", 32'(n_done), 1);
      push_frame(W * H);
      wait_line(0);                      // F3: early vs injected in captured line 1
      check("done_after_f2", 32'(n_done), 2);
      check("err_none", 32'(n_err), 0);
      check("queue_empty_f2", 32'(exp_q.size()), 0);
      check("hold_addr", 32'(wr_addr), LAST);
      check("hold_data", 32'(wr_data), 180);
      check("busy_armed", 32'(busy), 1);
      inj_ln = 3;
      push_frame(W);                     // captured line 0 before the injected edge
      push_frame(W * H);                 // restarted frame from address 0
      wait_line(1);
      check("h_total_600", 32'(h_total_meas), 600);
      check("v_total_8", 32'(v_total_meas), 8);
      wait_line(5);
      inj_ln = -1;
      check("err_pulse", 32'(n_err), 1);
      check("no_done_on_err", 32'(n_done), 2);
      check("restart_pending", 32'(exp_q.size()), W * H);
      wait_line(0);                      // F4: disarm mid-capture
      check("done_after_restart", 32'(n_done), 3);
      push_frame(W * H);
      wait_line(3);
      arm = 1'b0;
      wait_line(0);                      // F5: must stay idle
      check("done_after_disarm", 32'(n_done), 4);
      check("busy_after_disarm", 32'(busy), 0);
      check("queue_empty_f4", 32'(exp_q.size()), 0);

      // hs and vs falling together at the start of each frame.
      wait_line(5);
      vs_off = 0;
      arm    = 1'b1;
      wait_line(0);                      // F6
      push_frame(W * H);
      wait_line(0);                      // F7
      check("done_coincident", 32'(n_done), 5);
      push_frame(W * H);
      wait_line(1);
      check("v_total_coincident", 32'(v_total_meas), 7);

      // Reset mid-frame at write address 300.
      seen = 1'b0;
      for (int i = 0; i < 10000 && !seen; i++) begin
         @(negedge clk);
         if (wr_en && wr_addr == AW'(300)) seen = 1'b1;
      end
      check("reach_addr_300", 32'(seen), 1);
      #1;
      rst_n = 1'b0;
      arm   = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check_all_zero("midreset");
      rst_n = 1'b1;
      arm   = 1'b1;
      wait_line(0);                      // F8
      check("done_no_partial", 32'(n_done), 5);
      check("err_no_partial", 32'(n_err), 1);
      push_frame(W * H);
      wait_line(0);                      // F9
      check("done_after_rearm", 32'(n_done), 6);
      check("queue_empty_f8", 32'(exp_q.size()), 0);
      check("busy_rearmed", 32'(busy), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
